// File: rtl/rom_dl_pkg.sv
// Shared types and default constants for the ROM download scheduler.
package rom_dl_pkg;

  localparam logic [24:0] DEF_P2_BASE   = 25'h30000;
  localparam logic [24:0] DEF_PROM_BASE = 25'hA0000;
  localparam logic [15:0] DEF_HOLDOFF   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK
  } sched_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

endpackage

// File: rtl/dl_fifo2.sv
// Two-entry FIFO of download bytes; a push while full is discarded.
import rom_dl_pkg::*;

module dl_fifo2 (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  dl_entry_t din,
  output dl_entry_t dout,
  output logic      full,
  output logic      empty
);

  dl_entry_t  mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage, no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rom_dl_sched.sv
// ROM download scheduler: captures HPS bytes, routes them to SDRAM port1/port2
// or on-chip PROMs, and sequences rom_loaded / core_reset.
// Optional feature: define ROM_CHECKSUM_EN to add the rom_sum byte checksum output.
import rom_dl_pkg::*;

module rom_dl_sched #(
  parameter logic [15:0] HOLDOFF   = DEF_HOLDOFF,
  parameter logic [24:0] P2_BASE   = DEF_P2_BASE,
  parameter logic [24:0] PROM_BASE = DEF_PROM_BASE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] sd_a,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_d,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_d,
  output logic        prom_wr,
  output logic        rom_loaded,
  output logic        core_reset,
  input  logic        status_reset
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0] rom_sum
`endif
);

  sched_state_t state;
  dl_entry_t    head;
  dl_entry_t    cap_entry;
  logic         wr_q;
  logic         dl_q;
  logic         capture;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         p2_pend;
  logic         acks_done;
  logic         overrun;
  logic         load_pend;
  logic [15:0]  hold_cnt;

  assign capture    = ioctl_wr & ~wr_q & (ioctl_index == 8'd0);
  assign cap_entry  = '{addr: ioctl_addr, data: ioctl_dout};
  assign acks_done  = (port1_ack == port1_req) & (~p2_pend | (port2_ack == port2_req));
  assign ioctl_wait = fifo_full;
  assign core_reset = (hold_cnt != '0);

  dl_fifo2 u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (capture),
    .pop   (fifo_pop),
    .din   (cap_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pop is decoded from the current state so the FIFO retires the head on the
  // same edge the FSM leaves ISSUE (PROM) or WAIT_ACK (SDRAM).
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      S_ISSUE:    fifo_pop = (head.addr >= PROM_BASE);
      S_WAIT_ACK: fifo_pop = acks_done;
      default:    fifo_pop = 1'b0;
    endcase
  end

  // Scheduler FSM: dispatch the FIFO head to PROM or SDRAM and hold it until acked.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      port1_req <= 1'b0;
      port2_req <= 1'b0;
      p2_pend   <= 1'b0;
      sd_a      <= '0;
      sd_ds     <= '0;
      sd_d      <= '0;
      prom_addr <= '0;
      prom_d    <= '0;
      prom_wr   <= 1'b0;
    end else begin
      prom_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (head.addr >= PROM_BASE) begin
            prom_addr <= 12'(head.addr - PROM_BASE);
            prom_d    <= head.data;
            prom_wr   <= 1'b1;
            state     <= S_IDLE;
          end else begin
            sd_ds     <= {head.addr[0], ~head.addr[0]};
            sd_d      <= {2{head.data}};
            port1_req <= ~port1_req;
            if (head.addr >= P2_BASE) begin
              sd_a      <= 23'((head.addr - P2_BASE) >> 1);
              port2_req <= ~port2_req;
              p2_pend   <= 1'b1;
            end else begin
              sd_a    <= 23'(head.addr >> 1);
              p2_pend <= 1'b0;
            end
            state <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (acks_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Edge history, sticky overrun and rom_loaded sequencing around the download window.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      overrun    <= 1'b0;
      load_pend  <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
      if (capture && fifo_full) overrun <= 1'b1;
      if (ioctl_download && !dl_q) begin
        rom_loaded <= 1'b0;
        load_pend  <= 1'b0;
      end else if (!ioctl_download && dl_q) begin
        load_pend <= 1'b1;
      end else if (load_pend && fifo_empty && (state == S_IDLE)) begin
        rom_loaded <= 1'b1;
        load_pend  <= 1'b0;
      end
    end
  end

  // Core reset hold-off counter: reload while not loaded or on user reset, else count down.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_cnt <= HOLDOFF;
    end else if (status_reset || !rom_loaded) begin
      hold_cnt <= HOLDOFF;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 16'd1;
    end
  end

`ifdef ROM_CHECKSUM_EN
  // Running byte sum of accepted download bytes, restarted with each download.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_sum <= '0;
    end else if (ioctl_download && !dl_q) begin
      rom_sum <= '0;
    end else if (capture && !fifo_full) begin
      rom_sum <= rom_sum + {8'h00, ioctl_dout};
    end
  end
`endif

endmodule
